// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA job controller and its command wrappers.
//   rsa_job_state_t : controller state encoding
//   RSA_ST_*        : job status codes reported on the status output
//   id_width()      : width of a source index, never less than one bit
package rsa_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StClear,
      StRun,
      StDone
   } rsa_job_state_t;

   localparam logic [1:0] RSA_ST_NONE    = 2'b00;
   localparam logic [1:0] RSA_ST_OK      = 2'b01;
   localparam logic [1:0] RSA_ST_ABORTED = 2'b10;
   localparam logic [1:0] RSA_ST_TIMEOUT = 2'b11;

   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rsa_job_ctrl_if.sv
// Command/status bundle between the command wrappers, the job controller and the RSA unit.
//   master : command side (drives requests, unit feedback), observes status
//   slave  : the job controller
// Signals: ena, start_req, stop_req, irq_clr, timeout_val, unit_eoc, unit_c (to controller);
//          unit_en, unit_rstb, busy, result, status, src_id, irq, start_dropped (from it).
interface rsa_job_ctrl_if
   import rsa_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned NUM_SRC   = 2,
   parameter int unsigned TIMEOUT_W = 16
) ();

   localparam int unsigned ID_W = id_width(NUM_SRC);

   logic                 ena;
   logic [NUM_SRC-1:0]   start_req;
   logic [NUM_SRC-1:0]   stop_req;
   logic                 irq_clr;
   logic [TIMEOUT_W-1:0] timeout_val;
   logic                 unit_eoc;
   logic [WIDTH-1:0]     unit_c;

   logic                 unit_en;
   logic                 unit_rstb;
   logic                 busy;
   logic [WIDTH-1:0]     result;
   logic [1:0]           status;
   logic [ID_W-1:0]      src_id;
   logic                 irq;
   logic                 start_dropped;

   modport master (
      output ena, start_req, stop_req, irq_clr, timeout_val, unit_eoc, unit_c,
      input  unit_en, unit_rstb, busy, result, status, src_id, irq, start_dropped
   );

   modport slave (
      input  ena, start_req, stop_req, irq_clr, timeout_val, unit_eoc, unit_c,
      output unit_en, unit_rstb, busy, result, status, src_id, irq, start_dropped
   );

endinterface

// File: rtl/prio_enc.sv
// Lowest-index-wins priority encoder.
//   req   : request vector, bit 0 has highest priority
//   idx   : index of the lowest set bit (0 when none set)
//   valid : at least one request bit set
module prio_enc #(
   parameter int unsigned N    = 2,
   parameter int unsigned ID_W = 1
) (
   input  logic [N-1:0]    req,
   output logic [ID_W-1:0] idx,
   output logic            valid
);

   always_comb begin
      idx   = '0;
      valid = |req;
      // Scan downward so the lowest set bit is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/rsa_job_ctrl.sv
// RSA job controller: arbitrates start/stop from NUM_SRC sources, sequences reset/enable of the
// modular-exponentiation unit, enforces a programmable RUN timeout, latches the result and raises
// sticky interrupt / dropped-start flags.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : rsa_job_ctrl_if slave port (commands, unit feedback, unit control, status)
module rsa_job_ctrl
   import rsa_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned NUM_SRC   = 2,
   parameter int unsigned TIMEOUT_W = 16
) (
   input logic         clk,
   input logic         rst,
   rsa_job_ctrl_if.slave bus
);

   localparam int unsigned ID_W = id_width(NUM_SRC);

   rsa_job_state_t       state_q;
   logic [TIMEOUT_W-1:0] cnt_q;
   logic                 en_q;
   logic                 rstb_q;
   logic                 busy_q;
   logic [WIDTH-1:0]     result_q;
   logic [1:0]           status_q;
   logic [ID_W-1:0]      src_id_q;
   logic                 irq_q;
   logic                 dropped_q;

   logic                 start_any;
   logic [ID_W-1:0]      start_idx;
   logic                 stop_any;
   logic                 timeout_hit;
   logic                 run_exit;
   logic                 drop;

   prio_enc #(
      .N    (NUM_SRC),
      .ID_W (ID_W)
   ) u_prio_enc (
      .req   (bus.start_req),
      .idx   (start_idx),
      .valid (start_any)
   );

   assign stop_any    = |bus.stop_req;
   assign timeout_hit = (bus.timeout_val != '0) &&
                        (cnt_q == bus.timeout_val - TIMEOUT_W'(1));
   // Every way out of RUN, in one term, so irq cannot miss an exit path.
   assign run_exit    = bus.ena && (state_q == StRun) &&
                        (bus.unit_eoc || stop_any || timeout_hit);
   assign drop        = bus.ena && start_any &&
                        ((state_q == StClear) || (state_q == StRun));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         en_q      <= 1'b0;
         rstb_q    <= 1'b0;
         busy_q    <= 1'b0;
         result_q  <= '0;
         status_q  <= RSA_ST_NONE;
         src_id_q  <= '0;
         irq_q     <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         // Sticky flags: a new event beats a coincident clear. irq_clr works even with ena low.
         if (run_exit) begin
            irq_q <= 1'b1;
         end else if (bus.irq_clr) begin
            irq_q <= 1'b0;
         end

         if (drop) begin
            dropped_q <= 1'b1;
         end else if (bus.irq_clr) begin
            dropped_q <= 1'b0;
         end

         if (bus.ena) begin
            case (state_q)
               StIdle, StDone: begin
                  if (start_any) begin
                     state_q  <= StClear;
                     src_id_q <= start_idx;
                     cnt_q    <= '0;
                     en_q     <= 1'b0;
                     rstb_q   <= 1'b0;
                     busy_q   <= 1'b1;
                  end
               end
               StClear: begin
                  state_q <= StRun;
                  en_q    <= 1'b1;
                  rstb_q  <= 1'b1;
               end
               StRun: begin
                  if (cnt_q != '1) begin
                     cnt_q <= cnt_q + TIMEOUT_W'(1);
                  end
                  if (bus.unit_eoc) begin
                     // Unit stays out of reset so it keeps presenting C.
                     state_q  <= StDone;
                     result_q <= bus.unit_c;
                     status_q <= RSA_ST_OK;
                     en_q     <= 1'b0;
                     busy_q   <= 1'b0;
                  end else if (stop_any) begin
                     state_q  <= StIdle;
                     status_q <= RSA_ST_ABORTED;
                     en_q     <= 1'b0;
                     rstb_q   <= 1'b0;
                     busy_q   <= 1'b0;
                  end else if (timeout_hit) begin
                     state_q  <= StIdle;
                     status_q <= RSA_ST_TIMEOUT;
                     en_q     <= 1'b0;
                     rstb_q   <= 1'b0;
                     busy_q   <= 1'b0;
                  end
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   // ena gates the enable immediately so a frozen RUN never clocks the unit.
   assign bus.unit_en       = en_q & bus.ena;
   assign bus.unit_rstb     = rstb_q;
   assign bus.busy          = busy_q;
   assign bus.result        = result_q;
   assign bus.status        = status_q;
   assign bus.src_id        = src_id_q;
   assign bus.irq           = irq_q;
   assign bus.start_dropped = dropped_q;

endmodule

// File: tb/tb_rsa_job_ctrl.sv
module tb_rsa_job_ctrl;
   import rsa_pkg::*;

   localparam int unsigned WIDTH     = 8;
   localparam int unsigned NUM_SRC   = 2;
   localparam int unsigned TIMEOUT_W = 16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   rsa_job_ctrl_if #(
      .WIDTH     (WIDTH),
      .NUM_SRC   (NUM_SRC),
      .TIMEOUT_W (TIMEOUT_W)
   ) bus ();

   rsa_job_ctrl #(
      .WIDTH     (WIDTH),
      .NUM_SRC   (NUM_SRC),
      .TIMEOUT_W (TIMEOUT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [7:0] result;
      logic [1:0] status;
      logic       src_id;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [7:0] res, input logic [1:0] st, input logic src);
      exp_t e;
      e.result = res;
      e.status = st;
      e.src_id = src;
      sb_q.push_back(e);
   endtask

   // Drive a one-cycle start pulse; returns in the CLEAR cycle.
   task automatic launch(input logic [1:0] req);
      bus.start_req = req;
      tick();
      bus.start_req = '0;
   endtask

   task automatic pulse_irq_clr();
      bus.irq_clr = 1'b1;
      tick();
      bus.irq_clr = 1'b0;
   endtask

   // Called in the first cycle after a job ended.
   task automatic compare_end(input string tag);
      exp_t e;
      check({tag, "_sb_size"}, sb_q.size(), 1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check({tag, "_result"}, bus.result, e.result);
         check({tag, "_status"}, bus.status, e.status);
         check({tag, "_src_id"}, bus.src_id, e.src_id);
      end
      check({tag, "_irq"}, bus.irq, 1);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_unit_en"}, bus.unit_en, 0);
   endtask

   // Wait for busy to fall, counting enable cycles and RUN cycles on the way.
   task automatic wait_idle(input int limit, output int en_cnt, output int run_cnt);
      en_cnt  = 0;
      run_cnt = 0;
      for (int i = 0; i < limit; i++) begin
         if (!bus.busy) break;
         en_cnt  += int'(bus.unit_en);
         run_cnt += int'(bus.unit_rstb & bus.busy);
         tick();
      end
      check("wait_idle_bound", bus.busy, 0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_unit_en"}, bus.unit_en, 0);
      check({tag, "_unit_rstb"}, bus.unit_rstb, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_result"}, bus.result, 0);
      check({tag, "_status"}, bus.status, RSA_ST_NONE);
      check({tag, "_src_id"}, bus.src_id, 0);
      check({tag, "_irq"}, bus.irq, 0);
      check({tag, "_dropped"}, bus.start_dropped, 0);
   endtask

   initial begin
      int en_cnt;
      int run_cnt;

      rst             = 1'b1;
      bus.ena         = 1'b1;
      bus.start_req   = '0;
      bus.stop_req    = '0;
      bus.irq_clr     = 1'b0;
      bus.timeout_val = '0;
      bus.unit_eoc    = 1'b0;
      bus.unit_c      = '0;
      tick();
      tick();
      rst = 1'b0;
      check_reset("reset");

      // Basic job: start at cycle 0, eoc at cycle 10.
      launch(2'b01);
      check("t1_clear_busy", bus.busy, 1);
      check("t1_clear_en", bus.unit_en, 0);
      check("t1_clear_rstb", bus.unit_rstb, 0);
      push_exp(8'h5A, RSA_ST_OK, 1'b0);
      en_cnt = 0;
      for (int c = 2; c <= 10; c++) begin
         tick();
         en_cnt += int'(bus.unit_en);
      end
      bus.unit_eoc = 1'b1;
      bus.unit_c   = 8'h5A;
      tick();
      bus.unit_eoc = 1'b0;
      check("t1_en_cycles", en_cnt, 9);
      check("t1_done_rstb", bus.unit_rstb, 1);
      compare_end("t1");
      pulse_irq_clr();
      check("t1_irq_cleared", bus.irq, 0);
      check("t1_result_held", bus.result, 8'h5A);

      // Simultaneous starts from DONE, then a dropped start during RUN.
      launch(2'b11);
      push_exp(8'h33, RSA_ST_OK, 1'b0);
      tick();
      bus.start_req = 2'b10;
      tick();
      bus.start_req = '0;
      check("t2_dropped_set", bus.start_dropped, 1);
      check("t2_still_busy", bus.busy, 1);
      tick();
      bus.unit_eoc = 1'b1;
      bus.unit_c   = 8'h33;
      tick();
      bus.unit_eoc = 1'b0;
      compare_end("t2");
      check("t2_dropped_sticky", bus.start_dropped, 1);
      pulse_irq_clr();
      check("t2_dropped_cleared", bus.start_dropped, 0);
      check("t2_irq_cleared", bus.irq, 0);

      // Source 1 alone, aborted by stop.
      launch(2'b10);
      push_exp(8'h33, RSA_ST_ABORTED, 1'b1);
      tick();
      tick();
      bus.stop_req = 2'b01;
      tick();
      bus.stop_req = '0;
      check("t3_abort_rstb", bus.unit_rstb, 0);
      compare_end("t3");
      pulse_irq_clr();

      // Timeout of 5 with no eoc.
      bus.timeout_val = 16'd5;
      launch(2'b01);
      push_exp(8'h33, RSA_ST_TIMEOUT, 1'b0);
      wait_idle(50, en_cnt, run_cnt);
      check("t4_en_cycles", en_cnt, 5);
      check("t4_run_cycles", run_cnt, 5);
      check("t4_rstb", bus.unit_rstb, 0);
      compare_end("t4");
      pulse_irq_clr();

      // Stop and eoc in the same cycle: completion wins.
      bus.timeout_val = '0;
      launch(2'b01);
      push_exp(8'hC7, RSA_ST_OK, 1'b0);
      tick();
      tick();
      bus.stop_req = 2'b01;
      bus.unit_eoc = 1'b1;
      bus.unit_c   = 8'hC7;
      tick();
      bus.stop_req = '0;
      bus.unit_eoc = 1'b0;
      compare_end("t5");
      pulse_irq_clr();

      // Three ena-low cycles mid-RUN extend the timeout by three.
      bus.timeout_val = 16'd5;
      launch(2'b01);
      push_exp(8'hC7, RSA_ST_TIMEOUT, 1'b0);
      tick();
      en_cnt  = int'(bus.unit_en);
      run_cnt = int'(bus.unit_rstb & bus.busy);
      for (int g = 0; g < 3; g++) begin
         tick();
         bus.ena = 1'b0;
         #1;
         check("t6_gap_en", bus.unit_en, 0);
         check("t6_gap_busy", bus.busy, 1);
         run_cnt += int'(bus.unit_rstb & bus.busy);
      end
      tick();
      bus.ena = 1'b1;
      #1;
      begin
         int en2;
         int run2;
         wait_idle(50, en2, run2);
         en_cnt  += en2;
         run_cnt += run2;
      end
      check("t6_en_cycles", en_cnt, 5);
      check("t6_run_cycles", run_cnt, 8);
      compare_end("t6");
      pulse_irq_clr();

      // irq_clr coinciding with a job end: the set wins.
      bus.timeout_val = '0;
      launch(2'b01);
      push_exp(8'hA5, RSA_ST_OK, 1'b0);
      tick();
      bus.unit_eoc = 1'b1;
      bus.unit_c   = 8'hA5;
      bus.irq_clr  = 1'b1;
      tick();
      bus.unit_eoc = 1'b0;
      bus.irq_clr  = 1'b0;
      compare_end("t7");

      // Asynchronous reset mid-RUN.
      launch(2'b01);
      tick();
      tick();
      check("t8_run_en", bus.unit_en, 1);
      #2;
      rst = 1'b1;
      #1;
      check_reset("t8_async");
      tick();
      rst = 1'b0;
      tick();
      check_reset("t8_after");
      check("t8_sb_empty", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

endmodule
